// File: rtl/dmem_responder.sv
// Data-memory responder: stalls each core request LATENCY cycles, then commits the write or returns the read word.
// Define DMEM_RESP_TOHOST_EN to decode addr[31:28]==4'h8 as the memory-mapped tohost register.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        stall
`ifdef DMEM_RESP_TOHOST_EN
    ,
    output logic [31:0] tohost
`endif
);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [31:0]             dout_q;
    logic [31:0]             mem_q [2**DEPTH_LOG2];
    logic                    req;
    logic                    accept;
    logic                    isHost;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             hostWord;
    logic                    unused_addr;

    assign req         = re | (|we);
    assign idx         = addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef DMEM_RESP_TOHOST_EN
    logic [31:0] tohost_q;

    assign isHost   = (addr[31:28] == 4'h8);
    assign hostWord = tohost_q;
    assign tohost   = tohost_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tohost_q <= '0;
        end else if (accept && isHost) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) tohost_q[8*i +: 8] <= din[8*i +: 8];
            end
        end
    end
`else
    assign isHost   = 1'b0;
    assign hostWord = '0;
`endif

    // Stall is combinational so the core sees it in the cycle it presents the request.
    always_comb begin
        stall  = 1'b0;
        accept = 1'b0;
        if (reset && req) begin
            case (state_q)
                IDLE: begin
                    if (LATENCY == 0) accept = 1'b1;
                    else              stall  = 1'b1;
                end
                WAIT: begin
                    if (cnt_q != 4'd0) stall  = 1'b1;
                    else               accept = 1'b1;
                end
                default: begin
                    stall  = 1'b0;
                    accept = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && LATENCY != 0) begin
                        state_q <= WAIT;
                        cnt_q   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (!req || cnt_q == 4'd0) state_q <= IDLE;
                    else                       cnt_q   <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
            // Read sees the pre-write word when re and we arrive together.
            if (accept && re) dout_q <= isHost ? hostWord : mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !isHost) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem_q[idx][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances checked every cycle against a request-level model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addrS  [2];
    logic [3:0]  weS    [2];
    logic        reS    [2];
    logic [31:0] dinS   [2];
    logic [31:0] doutS  [2];
    logic        stallS [2];
`ifdef DMEM_RESP_TOHOST_EN
    logic [31:0] tohostS [2];
`endif

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(2)) dutLat2 (
        .clk(clk), .reset(rst_n), .addr(addrS[0]), .we(weS[0]), .re(reS[0]),
        .din(dinS[0]), .dout(doutS[0]), .stall(stallS[0])
`ifdef DMEM_RESP_TOHOST_EN
        , .tohost(tohostS[0])
`endif
    );

    dmem_responder #(.DEPTH_LOG2(12), .LATENCY(0)) dutLat0 (
        .clk(clk), .reset(rst_n), .addr(addrS[1]), .we(weS[1]), .re(reS[1]),
        .din(dinS[1]), .dout(doutS[1]), .stall(stallS[1])
`ifdef DMEM_RESP_TOHOST_EN
        , .tohost(tohostS[1])
`endif
    );

    // Model: a request must sit through latOf(k) stalled cycles before it is served.
    logic [31:0] mMem  [2][4096];
    logic [31:0] mDout [2];
    logic [31:0] mHost [2];
    int          waited[2];

    function automatic int latOf(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic bit hostAddr(logic [31:0] a);
`ifdef DMEM_RESP_TOHOST_EN
        return (a >> 28) == 32'd8;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                waited[k] = 0;
                mDout[k]  = 32'd0;
                mHost[k]  = 32'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!(reS[k] || weS[k] != 4'd0)) begin
                    waited[k] = 0;
                end else if (waited[k] < latOf(k)) begin
                    waited[k]++;
                end else begin
                    int          word;
                    logic [31:0] cur;
                    word = int'((addrS[k] >> 2) % 4096);
                    cur  = hostAddr(addrS[k]) ? mHost[k] : mMem[k][word];
                    if (reS[k]) mDout[k] = cur;
                    for (int i = 0; i < 4; i++) begin
                        if (weS[k][i]) cur[8*i +: 8] = dinS[k][8*i +: 8];
                    end
                    if (hostAddr(addrS[k])) mHost[k] = cur;
                    else                    mMem[k][word] = cur;
                    waited[k] = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                logic expStall;
                expStall = rst_n && (reS[k] || weS[k] != 4'd0) && (waited[k] < latOf(k));
                checkOutput("stall", k, {31'd0, stallS[k]}, {31'd0, expStall});
                checkOutput("dout", k, doutS[k], mDout[k]);
`ifdef DMEM_RESP_TOHOST_EN
                checkOutput("tohost", k, tohostS[k], mHost[k]);
`endif
            end
        end
    end

    // Present one request, hold it until accepted, then drop it; returns stalled-cycle count.
    task automatic applyStimulus(input int k, input logic [31:0] a, input logic [3:0] w,
                                 input logic r, input logic [31:0] d, output int stalls);
        bit done = 1'b0;
        addrS[k] = a; weS[k] = w; reS[k] = r; dinS[k] = d;
        stalls = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stallS[k]) done = 1'b1;
            else            stalls++;
            @(posedge clk); #1;
        end
        reS[k] = 1'b0; weS[k] = 4'd0;
        if (!done) checkOutput("accept_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic readCheck(input string name, input int k, input logic [31:0] a,
                             input logic [31:0] exp, input int expStalls);
        int s;
        applyStimulus(k, a, 4'd0, 1'b1, 32'd0, s);
        checkOutput({name, "_stalls"}, k, 32'(s), 32'(expStalls));
        @(negedge clk);
        checkOutput(name, k, doutS[k], exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int s;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            addrS[k] = '0; weS[k] = '0; reS[k] = 1'b0; dinS[k] = '0;
        end
        #3;
        rst_n = 1'b0;
        reS[0] = 1'b1; reS[1] = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("rst_stall", 0, {31'd0, stallS[0]}, 32'd0);
        checkOutput("rst_dout", 0, doutS[0], 32'd0);
        checkOutput("rst_dout", 1, doutS[1], 32'd0);
        @(posedge clk); #1;
        reS[0] = 1'b0; reS[1] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, 32'h100, 4'hF, 1'b0, 32'hDEADBEEF, s);
        checkOutput("wr_stalls", 0, 32'(s), 32'd2);
        readCheck("rd_100", 0, 32'h100, 32'hDEADBEEF, 2);

        applyStimulus(0, 32'h100, 4'b0101, 1'b0, 32'h11223344, s);
        readCheck("byte_en", 0, 32'h100, 32'hDE22BE44, 2);

        applyStimulus(0, 32'h104, 4'hF, 1'b0, 32'hAAAAAAAA, s);
        applyStimulus(0, 32'h104, 4'hF, 1'b1, 32'h55555555, s);
        @(negedge clk);
        checkOutput("rbw_old", 0, doutS[0], 32'hAAAAAAAA);
        @(posedge clk); #1;
        readCheck("rbw_new", 0, 32'h104, 32'h55555555, 2);

        // Abort: drop the write while the counter still has one cycle to go.
        applyStimulus(0, 32'h200, 4'hF, 1'b0, 32'hCAFEF00D, s);
        addrS[0] = 32'h200; weS[0] = 4'hF; dinS[0] = 32'h12345678;
        @(negedge clk);
        checkOutput("abort_stall_a", 0, {31'd0, stallS[0]}, 32'd1);
        @(posedge clk); #1;
        weS[0] = 4'd0;
        @(negedge clk);
        checkOutput("abort_stall_b", 0, {31'd0, stallS[0]}, 32'd0);
        @(posedge clk); #1;
        readCheck("abort_keep", 0, 32'h200, 32'hCAFEF00D, 2);

        // Reset mid-WAIT with the request still held.
        addrS[0] = 32'h100; reS[0] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_stall", 0, {31'd0, stallS[0]}, 32'd0);
        checkOutput("midrst_dout", 0, doutS[0], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        readCheck("post_rst", 0, 32'h100, 32'hDE22BE44, 2);

        applyStimulus(1, 32'h40, 4'hF, 1'b0, 32'h0BADF00D, s);
        checkOutput("lat0_wr_stalls", 1, 32'(s), 32'd0);
        readCheck("lat0_rd", 1, 32'h40, 32'h0BADF00D, 0);
        applyStimulus(1, 32'h40, 4'b1000, 1'b1, 32'hFF000000, s);
        @(negedge clk);
        checkOutput("lat0_rbw", 1, doutS[1], 32'h0BADF00D);
        @(posedge clk); #1;
        readCheck("lat0_merge", 1, 32'h40, 32'hFFADF00D, 0);

        applyStimulus(1, 32'h0, 4'hF, 1'b0, 32'h77777777, s);
        applyStimulus(1, 32'h80000000, 4'hF, 1'b0, 32'h00000001, s);
`ifdef DMEM_RESP_TOHOST_EN
        @(negedge clk);
        checkOutput("tohost_val", 1, tohostS[1], 32'h00000001);
        @(posedge clk); #1;
        readCheck("word0_kept", 1, 32'h0, 32'h77777777, 0);
        readCheck("tohost_rd", 1, 32'h80000000, 32'h00000001, 0);
`else
        readCheck("word0_alias", 1, 32'h0, 32'h00000001, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the core's data-memory port: accepts the core's address/byte-enable/read-enable/write-data requests, holds the core with `stall` for a programmable number of cycles, then commits writes into an internal word-addressed array and returns read data. Sits between the core's data port and nothing else; it is the synthesizable stand-in for the data cache/memory system used in bring-up and in core-level tests. Optionally decodes a single memory-mapped `tohost` register.

## Interface
- `DEPTH_LOG2`, 12, log2 of array depth in 32-bit words.
- `LATENCY`, 2, stall cycles per request, legal range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset: asserted when 0, takes effect immediately, released synchronously by design convention.
- `addr`  in  32  byte address from core; `addr[1:0]` ignored.
- `we`  in  4  byte write enables; `we[i]` writes `din[8i+7:8i]`.
- `re`  in  1  read enable.
- `din`  in  32  write data.
- `dout`  out  32  read data, registered.
- `stall`  out  1  hold request to core, combinational.
- `tohost`  out  32  MMIO register; present only with `DMEM_RESP_TOHOST_EN`.

## Operation
- Request present: `re | (|we)`. No request means no access; array and `dout` unchanged.
- Word index: `addr[DEPTH_LOG2+1:2]`; upper address bits ignored (aliasing), except the MMIO window when enabled.
- FSM states: IDLE, WAIT; 4-bit counter `cnt`.
- IDLE, request, `LATENCY==0`: `stall=0`, access performed at this edge, stay IDLE.
- IDLE, request, `LATENCY>0`: `stall=1`; edge -> WAIT, `cnt=LATENCY-1`.
- WAIT: `stall = (cnt != 0)`; edge with `cnt!=0`: `cnt--`. Edge with `cnt==0`: access performed, -> IDLE.
- WAIT with request removed (`re==0`, `we==0`): abort, `stall=0`, edge -> IDLE, no access.
- Accepting cycle: first cycle with request present and `stall==0`. `addr`/`we`/`re`/`din` are sampled in that cycle only; changes during stalled cycles are legal and ignored.
- Write: byte lanes with `we[i]==1` are updated; other lanes are preserved.
- Read: `dout` receives the addressed word at the accepting edge and holds it until the next accepted read.
- Simultaneous `re` and `we`: read-before-write; `dout` receives the pre-write word, and the write commits at the same edge.
- Back-to-back requests: each request pays the full `LATENCY`; there is no pipelining.

## Timing
- Reset values: state IDLE, `cnt=0`, `dout=0`, `stall=0` (forced 0 while `reset==0`), `tohost=0`. Array contents are not reset.
- Stall cycles per request: exactly `LATENCY`.
- Read data is visible on `dout` in the cycle after the accepting cycle.
- Write is visible to a read accepted in the next accepting cycle.
- Reset asserted mid-WAIT: abort immediately with no access; the first request after release stalls the full `LATENCY`.

## Configuration
- `DMEM_RESP_TOHOST_EN` defined: `addr[31:28]==4'h8` selects the `tohost` register, not the array.
  - Writes to it are byte-enabled into `tohost`.
  - Reads from it return `tohost`.
  - Same stall/latency rules apply.
  - `tohost` port present.
- `DMEM_RESP_TOHOST_EN` undefined: no `tohost` port or register; those addresses alias into the array like any other.

## Test plan
- Reset: assert `reset=0` with `re=1` -> `stall=0`, `dout=0`. Release -> first request stalls exactly `LATENCY` cycles.
- `LATENCY=2`:
  - Write `0xDEADBEEF` to `0x100` with `we=4'hF` -> `stall` high for 2 cycles.
  - Then read `0x100` -> `stall` 2 cycles; `dout=0xDEADBEEF` the cycle after accept.
- Byte enables: word `0xDEADBEEF`, write `din=0x11223344` with `we=4'b0101` -> read returns `0xDE22BE44`.
- Read-before-write: word `0xAAAAAAAA`, `re=1`, `we=4'hF`, `din=0x55555555` -> `dout=0xAAAAAAAA`; following read returns `0x55555555`.
- Abort and latency 0:
  - Drop `re`/`we` during WAIT with `cnt=1` -> next cycle IDLE, array unchanged.
  - `LATENCY=0` -> `stall` never asserts; read data appears the next cycle.
- With `DMEM_RESP_TOHOST_EN`: write `0x00000001` to `0x80000000` -> `tohost=1`, array word 0 unchanged. Without the macro, the same write lands in array word 0.
